// File: rtl/cpu_checker_param.sv
// Trace-line checker: parses register/memory write lines one ASCII char per clock and
// reports line type plus semantic error flags. Optional macro: CHECKER_STRICT_HEX_EN.
module cpu_checker_param #(
  parameter int          TIME_DIGITS_MAX = 4,
  parameter int          GRF_DIGITS_MAX  = 4,
  parameter int          GRF_MAX         = 31,
  parameter logic [31:0] PC_MIN          = 32'h0000_3000,
  parameter logic [31:0] PC_MAX          = 32'h0000_4FFF,
  parameter logic [31:0] ADDR_MIN        = 32'h0000_0000,
  parameter logic [31:0] ADDR_MAX        = 32'h0000_2FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  char,
  input  logic [15:0] freq,
  output logic [1:0]  format_type,
  output logic [3:0]  error_code
);

  typedef enum logic [3:0] {
    IDLE, TIME, PC, COLON, SP1, GRF, ADDR, SP2, LT, SP3, DATA, SP4,
    DONE_REG, DONE_MEM, ERR
  } state_e;

  localparam logic [7:0]  TIME_CNT_MAX = 8'(TIME_DIGITS_MAX);
  localparam logic [7:0]  GRF_CNT_MAX  = 8'(GRF_DIGITS_MAX);
  localparam logic [15:0] GRF_LIMIT    = 16'(GRF_MAX);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] time_q, time_d;
  logic [15:0] grf_q, grf_d;
  logic [31:0] hex_q, hex_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        mem_q, mem_d;
  logic [3:0]  err_q, err_d;

  logic        is_dec, is_hex, bad;
  logic [3:0]  nib;
  logic [31:0] hex_next;
  logic [15:0] time_next, grf_next;

  always_comb begin
    is_dec = (char >= "0") && (char <= "9");
`ifdef CHECKER_STRICT_HEX_EN
    is_hex = is_dec || ((char >= "a") && (char <= "f"));
`else
    is_hex = is_dec || ((char >= "a") && (char <= "f")) || ((char >= "A") && (char <= "F"));
`endif
    // Letters a-f and A-F share the same low nibble offset from 10.
    nib       = is_dec ? char[3:0] : (char[3:0] + 4'd9);
    hex_next  = {hex_q[27:0], nib};
    time_next = (time_q * 16'd10) + {12'd0, char[3:0]};
    grf_next  = (grf_q * 16'd10) + {12'd0, char[3:0]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    time_d  = time_q;
    grf_d   = grf_q;
    hex_d   = hex_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    mem_d   = mem_q;
    err_d   = err_q;
    bad     = 1'b0;

    case (state_q)
      IDLE, DONE_REG, DONE_MEM: begin
        if (char == "^") begin
          state_d = TIME;
          cnt_d   = 8'd0;
          time_d  = 16'd0;
        end else begin
          state_d = IDLE;
        end
      end
      TIME: begin
        if (is_dec && (cnt_q < TIME_CNT_MAX)) begin
          cnt_d  = cnt_q + 8'd1;
          time_d = time_next;
        end else if ((char == "@") && (cnt_q != 8'd0)) begin
          state_d = PC;
          cnt_d   = 8'd0;
          hex_d   = 32'd0;
        end else begin
          bad = 1'b1;
        end
      end
      PC: begin
        if (is_hex) begin
          hex_d = hex_next;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd7) begin
            pc_d    = hex_next;
            state_d = COLON;
          end
        end else begin
          bad = 1'b1;
        end
      end
      COLON: begin
        if (char == ":") state_d = SP1;
        else             bad     = 1'b1;
      end
      SP1: begin
        if (char == "$") begin
          state_d = GRF;
          cnt_d   = 8'd0;
          grf_d   = 16'd0;
          mem_d   = 1'b0;
        end else if (char == "*") begin
          state_d = ADDR;
          cnt_d   = 8'd0;
          hex_d   = 32'd0;
          mem_d   = 1'b1;
        end else if (char != " ") begin
          bad = 1'b1;
        end
      end
      GRF: begin
        if (is_dec && (cnt_q < GRF_CNT_MAX)) begin
          cnt_d = cnt_q + 8'd1;
          grf_d = grf_next;
        end else if ((char == " ") && (cnt_q != 8'd0)) begin
          state_d = SP2;
        end else if ((char == "<") && (cnt_q != 8'd0)) begin
          state_d = LT;
        end else begin
          bad = 1'b1;
        end
      end
      ADDR: begin
        if (is_hex) begin
          hex_d = hex_next;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd7) begin
            addr_d  = hex_next;
            state_d = SP2;
          end
        end else begin
          bad = 1'b1;
        end
      end
      SP2: begin
        if (char == "<")      state_d = LT;
        else if (char != " ") bad     = 1'b1;
      end
      LT: begin
        if (char == "=") state_d = SP3;
        else             bad     = 1'b1;
      end
      SP3: begin
        if (is_hex) begin
          state_d = DATA;
          cnt_d   = 8'd1;
          hex_d   = {28'd0, nib};
        end else if (char != " ") begin
          bad = 1'b1;
        end
      end
      DATA: begin
        if (is_hex) begin
          hex_d = hex_next;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd7) state_d = SP4;
        end else begin
          bad = 1'b1;
        end
      end
      SP4: begin
        if (char == "#") begin
          state_d  = mem_q ? DONE_MEM : DONE_REG;
          err_d[0] = |(time_q & ((freq >> 1) - 16'd1));
          err_d[1] = (pc_q[1:0] != 2'd0) || ((pc_q - PC_MIN) > (PC_MAX - PC_MIN));
          err_d[2] = mem_q && ((addr_q[1:0] != 2'd0) ||
                               ((addr_q - ADDR_MIN) > (ADDR_MAX - ADDR_MIN)));
          err_d[3] = !mem_q && (grf_q > GRF_LIMIT);
        end else if (char != " ") begin
          bad = 1'b1;
        end
      end
      ERR: begin
        if (char == "#") state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // An illegal '#' already terminates the line, so skip ERR and resync at once.
    if (bad) state_d = (char == "#") ? IDLE : ERR;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      time_q  <= 16'd0;
      grf_q   <= 16'd0;
      hex_q   <= 32'd0;
      pc_q    <= 32'd0;
      addr_q  <= 32'd0;
      mem_q   <= 1'b0;
      err_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      time_q  <= time_d;
      grf_q   <= grf_d;
      hex_q   <= hex_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      mem_q   <= mem_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    format_type = 2'd0;
    error_code  = 4'd0;
    if (state_q == DONE_REG) begin
      format_type = 2'd1;
      error_code  = err_q;
    end else if (state_q == DONE_MEM) begin
      format_type = 2'd2;
      error_code  = err_q;
    end
  end

endmodule

// File: tb/tb_cpu_checker_param.sv
// Directed bench for cpu_checker_param: streams trace lines and checks the one-cycle
// format_type/error_code pulse after each terminating '#'.
module tb_cpu_checker_param;

  logic        clk;
  logic        reset;
  logic [7:0]  char;
  logic [15:0] freq;
  logic [1:0]  format_type;
  logic [3:0]  error_code;

  int checks = 0;
  int errors = 0;

  cpu_checker_param dut (
    .clk         (clk),
    .reset       (reset),
    .char        (char),
    .freq        (freq),
    .format_type (format_type),
    .error_code  (error_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled on the negedge just before the next char is applied.
  task automatic drive(input string s, input bit chk_first, input logic [1:0] first_ft);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      if (i == 0 && chk_first) begin
        check("first_ft", {2'b00, format_type}, {2'b00, first_ft});
        check("first_ec", error_code, 4'd0);
      end else if (i > 0) begin
        check("inline_ft", {2'b00, format_type}, 4'd0);
        check("inline_ec", error_code, 4'd0);
      end
      char = s[i];
    end
  endtask

  task automatic expect_pulse(input string tag, input logic [1:0] ft, input logic [3:0] ec);
    @(negedge clk);
    check({tag, "_ft"}, {2'b00, format_type}, {2'b00, ft});
    check({tag, "_ec"}, error_code, ec);
    char = " ";
    @(negedge clk);
    check({tag, "_after_ft"}, {2'b00, format_type}, 4'd0);
    check({tag, "_after_ec"}, error_code, 4'd0);
  endtask

  string l_reg = "^242@000030f4: $31 <=12345678#";
  string l_mem = "^338@00003130: *00000088 <= Ffffb528#";
  logic [1:0] mem_ft;

  initial begin
    reset = 1'b0;
    char  = 8'h00;
    freq  = 16'd2;
`ifdef CHECKER_STRICT_HEX_EN
    mem_ft = 2'd0;
`else
    mem_ft = 2'd2;
`endif
    repeat (2) @(negedge clk);
    check("reset_ft", {2'b00, format_type}, 4'd0);
    check("reset_ec", error_code, 4'd0);
    reset = 1'b1;

    drive(l_reg, 1'b0, 2'd0);
    expect_pulse("reg_ok", 2'd1, 4'd0);

    drive(l_mem, 1'b0, 2'd0);
    expect_pulse("mem_upper", mem_ft, 4'd0);

    drive("^242@000030f4: $31 <= 1232156#", 1'b0, 2'd0);
    expect_pulse("data7", 2'd0, 4'd0);
    drive(l_reg, 1'b0, 2'd0);
    expect_pulse("rec_data7", 2'd1, 4'd0);

    drive("^242@000030f4: $31 <=#", 1'b0, 2'd0);
    expect_pulse("data_empty", 2'd0, 4'd0);
    drive(l_reg, 1'b0, 2'd0);
    expect_pulse("rec_empty", 2'd1, 4'd0);

    drive("^12345@000030f4: $31 <=12345678#", 1'b0, 2'd0);
    expect_pulse("time5", 2'd0, 4'd0);
    drive(l_reg, 1'b0, 2'd0);
    expect_pulse("rec_time5", 2'd1, 4'd0);

    drive("^242@000030f4: $31 < =12345678#", 1'b0, 2'd0);
    expect_pulse("lt_space", 2'd0, 4'd0);
    drive(l_reg, 1'b0, 2'd0);
    expect_pulse("rec_lt", 2'd1, 4'd0);

    freq = 16'd8;
    drive(l_reg, 1'b0, 2'd0);
    expect_pulse("time_gran", 2'd1, 4'b0001);
    freq = 16'd2;

    drive("^242@00003131: $31 <=12345678#", 1'b0, 2'd0);
    expect_pulse("pc_align", 2'd1, 4'b0010);

    drive("^338@00003130: *00003000 <= 00000000#", 1'b0, 2'd0);
    expect_pulse("addr_range", 2'd2, 4'b0100);

    drive("^242@000030f4: $32 <=12345678#", 1'b0, 2'd0);
    expect_pulse("grf_range", 2'd1, 4'b1000);

    drive("^242@000030f4: $31 <=   123215 #", 1'b0, 2'd0);
    expect_pulse("data6_sp", 2'd0, 4'd0);

    drive(l_reg, 1'b0, 2'd0);
    drive("^338@00003130: *00000088 <= ffffb528#", 1'b1, 2'd1);
    expect_pulse("b2b_second", 2'd2, 4'd0);

    drive("^242@0000", 1'b0, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midreset_ft", {2'b00, format_type}, 4'd0);
    check("midreset_ec", error_code, 4'd0);
    reset = 1'b1;
    drive("30f4: $31 <=12345678#", 1'b0, 2'd0);
    expect_pulse("resume", 2'd0, 4'd0);
    drive(l_reg, 1'b0, 2'd0);
    expect_pulse("fresh", 2'd1, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_checker_param.md
Name: cpu_checker_param

Overview:
- Parametrised successor to the single-format CPU trace-line checker. Consumes one ASCII character per clock from the simulation trace stream.
- Recognises register-write lines `^<time>@<pc>: $<grf> <= <data>#` and memory-write lines `^<time>@<pc>: *<addr> <= <data>#`.
- Reports the line type and a 4-bit semantic error code in the cycle after the terminating `#`.
- Sits between the trace character source and the pre-project grading bench. Digit limits and legal PC/address windows are configurable.

Parameters:
- TIME_DIGITS_MAX, 4, maximum decimal digits in the time field (minimum 1).
- GRF_DIGITS_MAX, 4, maximum decimal digits in the register-number field (minimum 1).
- GRF_MAX, 31, highest legal register number.
- PC_MIN, 32'h0000_3000, lowest legal PC, inclusive.
- PC_MAX, 32'h0000_4FFF, highest legal PC, inclusive.
- ADDR_MIN, 32'h0000_0000, lowest legal memory address, inclusive.
- ADDR_MAX, 32'h0000_2FFF, highest legal memory address, inclusive.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset.
- char  input  8  ASCII character, sampled every posedge.
- freq  input  16  time granularity; a power of two, at least 2.
- format_type  output  2  0 = none/invalid, 1 = register-write line, 2 = memory-write line.
- error_code  output  4  error flags, valid only while format_type != 0; 0 otherwise.

Behaviour:
- Reset: reset==0 at a posedge puts the FSM in IDLE and clears all accumulators. format_type=0 and error_code=0 from the next cycle.
- Reset takes priority at any point, including mid-line; the partial line is discarded.
- Outputs are pure decodes of the registered state; they carry no combinational path from char.
- FSM states, in order: IDLE, TIME, PC, COLON, SP1, GRF, ADDR, SP2, LT, SP3, DATA, SP4, DONE_REG, DONE_MEM, ERR.
- Transitions:
  - IDLE: `^` → TIME; any other char stays in IDLE.
  - TIME: decimal digit accumulates, with count ≤ TIME_DIGITS_MAX. `@` with count ≥ 1 → PC.
  - PC: 8 hex digits, then `:` → SP1.
  - SP1: spaces ignored. `$` → GRF; `*` → ADDR.
  - GRF: 1..GRF_DIGITS_MAX decimal digits.
  - ADDR: exactly 8 hex digits.
  - SP2: spaces ignored; `<` → LT.
  - LT: `=` only, no space between `<` and `=`; → SP3.
  - SP3: spaces ignored; the first hex digit enters DATA.
  - DATA: exactly 8 hex digits, then SP4.
  - SP4: spaces ignored; `#` → DONE_REG or DONE_MEM, according to which field was parsed.
- Any character not listed for the current state, or any digit count out of range, sends the FSM to ERR.
- ERR holds until `#`, then → IDLE. A `^` seen in ERR is ignored.
- DONE_REG / DONE_MEM last exactly one cycle. format_type is 1 or 2 during that cycle. The character sampled on that same edge is handled as in IDLE, so back-to-back lines are supported.
- Hex digits accept 0-9, a-f and A-F.
- Decimal accumulators are 16 bits wide: value ← value*10 + digit. The hex accumulator is 32 bits: value ← {value[27:0], nibble}.
- error_code is computed when `#` is accepted and registered alongside format_type:
  - bit0: time & ((freq>>1)-1) != 0.
  - bit1: pc[1:0] != 0, or pc outside [PC_MIN, PC_MAX].
  - bit2: memory line only; addr[1:0] != 0, or addr outside [ADDR_MIN, ADDR_MAX].
  - bit3: register line only; grf > GRF_MAX.
- freq is sampled at the `#` edge.
- Invalid lines never raise format_type or error_code.

Optional Feature:
- CHECKER_STRICT_HEX_EN defined: hex fields accept only 0-9 and a-f; an uppercase A-F sends the FSM to ERR.
- Not defined: uppercase and lowercase hex are both accepted.

Test Plan:
- freq=2, line `^242@000030f4: $31 <=12345678#` → one cycle with format_type=1, error_code=0. Every other cycle reads 0.
- freq=2, line `^338@00003130: *00000088 <= Ffffb528#` → format_type=2, error_code=0 without the macro. With CHECKER_STRICT_HEX_EN, format_type stays 0.
- Field-count errors, each → format_type stays 0, and a following valid line is still recognised:
  - data `1232156` (7 digits);
  - empty data `<=#`;
  - 5-digit time `^12345@`;
  - `< =` (space between `<` and `=`).
- Semantic errors on otherwise valid lines:
  - freq=8, time 242 → error_code=4'b0001;
  - pc 00003131 → 4'b0010;
  - mem addr 00003000 → 4'b0100;
  - `$32` → 4'b1000.
- Spacing and back-to-back: `<=   123215 #` (6 data digits) → invalid. Two valid lines sent back-to-back with no gap → two separate one-cycle pulses, 1 then 2.
- Reset mid-line: drive reset=0 for one cycle after `^242@0000` → outputs 0. Resuming with `30f4:...#` gives no pulse; a fresh complete line afterwards pulses normally.
